// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues single outstanding imem fetches and buffers the returned instruction for decode
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INSN = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            zero_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
);
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_t;
  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n, fetch_pc, fetch_pc_n, inst_pc, inst_pc_n, target;
  logic [31:0]     inst, inst_n;
  logic            kill, kill_n, inst_valid, inst_valid_n;
  logic            req, redir, issue, resp, load, consume;
  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_BOOT;
    else       state <= state_n;
  end
  // next state: leave REQ only on an accepted request, leave WAIT only on the response
  always_comb begin
    state_n = state == S_BOOT ? S_REQ :
              state == S_REQ  ? (issue ? S_WAIT : S_REQ) :
                                (imem_rvalid_i ? S_REQ : S_WAIT);
  end
  // request only when the buffer is empty or is being drained this cycle
  always_comb begin
    req = state == S_REQ && (!inst_valid || !stall_i);
  end
  // datapath next values; a redirect wins over stall and over the sequential pc+4 step
  always_comb begin
    redir        = jump_i | (branch_i & zero_i);
    target       = br_pc_i + imm_i;
    issue        = req & imem_gnt_i;
    resp         = state == S_WAIT && imem_rvalid_i;
    load         = resp && !kill && !redir;
    consume      = inst_valid && !stall_i;
    pc_n         = redir ? {target[XLEN-1:2], 2'b00} : load ? pc + XLEN'(4) : pc;
    kill_n       = resp ? 1'b0 : (redir && (state == S_WAIT || issue)) ? 1'b1 : kill;
    fetch_pc_n   = issue ? pc : fetch_pc;
    inst_valid_n = redir ? 1'b0 : load ? 1'b1 : consume ? 1'b0 : inst_valid;
    inst_n       = redir ? NOP_INSN : load ? imem_rdata_i : consume ? NOP_INSN : inst;
    inst_pc_n    = load ? fetch_pc : inst_pc;
  end
  // datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc         <= RESET_PC;
      kill       <= 1'b0;
      fetch_pc   <= '0;
      inst_valid <= 1'b0;
      inst       <= NOP_INSN;
      inst_pc    <= '0;
    end else begin
      pc         <= pc_n;
      kill       <= kill_n;
      fetch_pc   <= fetch_pc_n;
      inst_valid <= inst_valid_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
    end
  end
  assign imem_req_o   = req;
  assign imem_addr_o  = pc;
  assign pc_o         = pc;
  assign inst_valid_o = inst_valid;
  assign inst_o       = inst;
  assign inst_pc_o    = inst_pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenario tests for fetch_ctrl against a latency-configurable instruction memory
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk_i, rst_i, jump_i, branch_i, zero_i, stall_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i, inst_valid_o;
  logic [31:0] br_pc_i, imm_i, imem_addr_o, imem_rdata_i, pc_o, inst_o, inst_pc_o;
  int          checks = 0, errors = 0;
  int          delay_cfg = 1, cnt = 0;
  logic [31:0] paddr = '0;

  fetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .jump_i(jump_i), .branch_i(branch_i), .zero_i(zero_i),
    .br_pc_i(br_pc_i), .imm_i(imm_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
  );

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // memory: response arrives delay_cfg cycles after the granting edge, data tagged by address
  always @(negedge clk_i) begin
    imem_rvalid_i = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = tag(paddr);
      end
    end
    if (imem_req_o && imem_gnt_i) begin
      paddr = imem_addr_o;
      cnt   = delay_cfg;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic ev, er;
    rst_i = 0; jump_i = 0; branch_i = 0; zero_i = 0; stall_i = 0;
    br_pc_i = '0; imm_i = '0; imem_gnt_i = 1; imem_rvalid_i = 0; imem_rdata_i = '0;
    #2 rst_i = 1;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
    checks++; if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP); end
    checks++; if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_o); end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ev = k >= 3 && k % 2 == 1;
      er = k % 2 == 1;
      checks++; if (inst_valid_o !== ev) begin errors++; $display("FAIL seq_valid k=%0d: got %b want %b", k, inst_valid_o, ev); end
      if (ev) begin
        checks++; if (inst_pc_o !== 32'((k - 3) * 2)) begin errors++; $display("FAIL seq_inst_pc k=%0d: got %h want %h", k, inst_pc_o, 32'((k - 3) * 2)); end
        checks++; if (inst_o !== tag(32'((k - 3) * 2))) begin errors++; $display("FAIL seq_inst k=%0d: got %h want %h", k, inst_o, tag(32'((k - 3) * 2))); end
      end
      checks++; if (imem_req_o !== er) begin errors++; $display("FAIL seq_req k=%0d: got %b want %b", k, imem_req_o, er); end
      if (er) begin
        checks++; if (imem_addr_o !== 32'((k - 1) * 2)) begin errors++; $display("FAIL seq_addr k=%0d: got %h want %h", k, imem_addr_o, 32'((k - 1) * 2)); end
      end
    end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h8) begin errors++; $display("FAIL stall_pre: got v=%b pc=%h want v=1 pc=8", inst_valid_o, inst_pc_o); end
    stall_i = 1;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req_low: got %b want 0", imem_req_o); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h8 || inst_o !== tag(32'h8)) begin errors++; $display("FAIL stall_hold k=%0d: got v=%b pc=%h inst=%h want v=1 pc=8 inst=%h", k, inst_valid_o, inst_pc_o, inst_o, tag(32'h8)); end
      checks++; if (imem_req_o !== 1'b0 || pc_o !== 32'hC) begin errors++; $display("FAIL stall_no_fetch k=%0d: got req=%b pc=%h want req=0 pc=c", k, imem_req_o, pc_o); end
    end
    stall_i = 0;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin errors++; $display("FAIL stall_release_req: got req=%b addr=%h want req=1 addr=c", imem_req_o, imem_addr_o); end
    tick();
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin errors++; $display("FAIL stall_drained: got v=%b inst=%h want v=0 inst=%h", inst_valid_o, inst_o, NOP); end
    tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hC || inst_o !== tag(32'hC)) begin errors++; $display("FAIL stall_next: got v=%b pc=%h inst=%h want v=1 pc=c", inst_valid_o, inst_pc_o, inst_o); end
  endtask

  task automatic test_jump();
    jump_i = 1; br_pc_i = 32'h10; imm_i = 32'h8; imem_gnt_i = 0;
    tick();
    jump_i = 0; imem_gnt_i = 1;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h18) begin errors++; $display("FAIL jump_addr: got req=%b addr=%h want req=1 addr=18", imem_req_o, imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin errors++; $display("FAIL jump_flush: got v=%b inst=%h want v=0 inst=%h", inst_valid_o, inst_o, NOP); end
    tick(); tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h18 || inst_o !== tag(32'h18)) begin errors++; $display("FAIL jump_first: got v=%b pc=%h inst=%h want v=1 pc=18", inst_valid_o, inst_pc_o, inst_o); end
    tick(); tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h1C) begin errors++; $display("FAIL jump_second: got v=%b pc=%h want v=1 pc=1c", inst_valid_o, inst_pc_o); end
  endtask

  task automatic test_kill();
    delay_cfg = 2;
    tick(); tick(); tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h20) begin errors++; $display("FAIL kill_pre: got v=%b pc=%h want v=1 pc=20", inst_valid_o, inst_pc_o); end
    tick();
    branch_i = 1; zero_i = 1; br_pc_i = 32'h20; imm_i = 32'hA;
    tick();
    branch_i = 0; zero_i = 0;
    #1;
    checks++; if (pc_o !== 32'h28 || imem_req_o !== 1'b0) begin errors++; $display("FAIL kill_redirect: got pc=%h req=%b want pc=28 req=0", pc_o, imem_req_o); end
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL kill_drop: got v=%b want 0", inst_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h28) begin errors++; $display("FAIL kill_refetch: got req=%b addr=%h want req=1 addr=28", imem_req_o, imem_addr_o); end
    delay_cfg = 1;
    tick(); tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h28 || inst_o !== tag(32'h28)) begin errors++; $display("FAIL kill_after: got v=%b pc=%h inst=%h want v=1 pc=28", inst_valid_o, inst_pc_o, inst_o); end
  endtask

  task automatic test_wrap_reset();
    jump_i = 1; br_pc_i = 32'h10; imm_i = 32'hFFFF_FFEC; imem_gnt_i = 0;
    tick();
    jump_i = 0; imem_gnt_i = 1;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got req=%b addr=%h want req=1 addr=fffffffc", imem_req_o, imem_addr_o); end
    tick(); tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_deliver: got v=%b pc=%h want v=1 pc=fffffffc", inst_valid_o, inst_pc_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
    repeat (5) tick();
    checks++; if (pc_o !== 32'h8 || imem_req_o !== 1'b0 || inst_pc_o !== 32'h4) begin errors++; $display("FAIL pre_reset_wait: got pc=%h req=%b ipc=%h want pc=8 req=0 ipc=4", pc_o, imem_req_o, inst_pc_o); end
    #2 rst_i = 1;
    #1;
    checks++; if (pc_o !== 32'h0 || inst_pc_o !== 32'h0 || inst_valid_o !== 1'b0 || inst_o !== NOP || imem_req_o !== 1'b0) begin errors++; $display("FAIL async_reset: got pc=%h ipc=%h v=%b inst=%h req=%b want all reset", pc_o, inst_pc_o, inst_valid_o, inst_o, imem_req_o); end
    @(negedge clk_i);
    #1 rst_i = 0;
    tick();
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin errors++; $display("FAIL stale_rvalid: got v=%b inst=%h want v=0 inst=%h", inst_valid_o, inst_o, NOP); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL restart_req: got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
    tick(); tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0 || inst_o !== tag(32'h0)) begin errors++; $display("FAIL restart_deliver: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h", inst_valid_o, inst_pc_o, inst_o, tag(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_jump();
    test_kill();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
